hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard and stall controller for the ID/EX boundary. It compares the decode-stage sources
//  against the instruction now held in ID/EX and reacts to EX branch resolution and to a
//  busy data memory. It drives the PC write enable, IF/ID write and flush, and the ID/EX
//  bubble and hold controls.
//  Counts stall and flush cycles for performance monitoring.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles of squash per taken branch (>=1); cycles beyond the first are extra wrong-path squash
//  CNT_W         32  width of the performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high
//  IF_ID_rs1       in   5      rs1 field of the instruction in decode
//  IF_ID_rs2       in   5      rs2 field of the instruction in decode
//  id_uses_rs1     in   1      decode instruction reads rs1
//  id_uses_rs2     in   1      decode instruction reads rs2
//  ID_EX_rd        in   5      rd of the instruction in EX
//  ID_EX_MemRead   in   1      instruction in EX is a load
//  branch_taken    in   1      EX resolved a taken branch this cycle
//  mem_busy        in   1      data memory is not ready; the whole pipe must freeze
//  pc_write        out  1      PC register load enable
//  if_id_write     out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID loads a NOP
//  id_ex_bubble    out  1      ID/EX loads zeroed control signals (regwrite, MemRead, MemWrite, branch)
//  id_ex_hold      out  1      ID/EX keeps its current contents
//  stall_count     out  CNT_W  saturating count of load-use and mem_busy stall cycles
//  flush_count     out  CNT_W  saturating count of flush cycles
// BEHAVIOUR
//  - load_use = ID_EX_MemRead & (ID_EX_rd!=0) & ((id_uses_rs1 & IF_ID_rs1==ID_EX_rd) | (id_uses_rs2 & IF_ID_rs2==ID_EX_rd)).
//  - FSM states: RUN and FLUSH. A down-counter fcnt is sized for FLUSH_CYCLES.
//  - Outputs are combinational from the state and inputs; the action applies in the same cycle.
//  - Priority, highest first: reset > mem_busy > (RUN & branch_taken) or FLUSH > load_use > normal.
//  - reset asserted (at any time, including mid-stall or mid-flush): state=RUN, fcnt=0, counters=0.
//    Outputs during reset: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, id_ex_hold=0.
//  - mem_busy=1, any state: pc_write=0, if_id_write=0, id_ex_hold=1, if_id_flush=0, id_ex_bubble=0.
//    State and fcnt are frozen; stall_count increments.
//    A branch_taken raised during mem_busy is not lost: EX is frozen, so it is acted on in the first non-busy cycle.
//  - RUN & branch_taken: pc_write=1 (PC loads target), if_id_write=1, if_id_flush=1, id_ex_bubble=1.
//    flush_count increments.
//    If FLUSH_CYCLES>1: next state FLUSH with fcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
//    The branch overrides any simultaneous load_use, because the decode instruction is squashed.
//  - FLUSH: outputs as for a branch; flush_count increments; fcnt decrements.
//    Return to RUN on the cycle fcnt==1.
//    branch_taken and load_use are ignored in FLUSH, since EX holds only bubbles.
//  - RUN & load_use (no branch, no mem_busy): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
//    stall_count increments. The stall lasts exactly 1 cycle: the bubble clears ID_EX_MemRead on the next edge.
//  - Normal: pc_write=1, if_id_write=1, all other controls 0.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - id_ex_hold and id_ex_bubble are never both 1.
// TESTING
//  1. reset=1 for 3 cycles, then released -> pc_write=0 and id_ex_bubble=1 during reset; counters=0;
//     pc_write=1 in the first cycle after release.
//  2. ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5, id_uses_rs2=1 -> exactly 1 cycle with pc_write=0 and
//     id_ex_bubble=1; stall_count=1. Same stimulus with ID_EX_rd=0 -> no stall.
//  3. branch_taken=1 for 1 cycle, FLUSH_CYCLES=2 -> if_id_flush=1 and id_ex_bubble=1 for 2 consecutive cycles;
//     flush_count=2; back in RUN.
//  4. branch_taken and a load_use hazard in the same cycle -> flush only; stall_count unchanged.
//  5. mem_busy=1 for 4 cycles in the middle of FLUSH (fcnt=1) -> 4 cycles with id_ex_hold=1 and pc_write=0;
//     then 1 more flush cycle; stall_count+=4.
//  6. reset pulsed mid-FLUSH -> immediate return to RUN; counters=0. With CNT_W=4 and 20 stalls -> stall_count=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : ID/EX hazard, branch-flush and memory-stall controller with
//            saturating stall and flush performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state;
  logic [FW-1:0] fcnt;
  logic          load_use;
  logic          flushing;

  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((id_uses_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                     (id_uses_rs2 && (IF_ID_rs2 == ID_EX_rd)));

  assign flushing = (state == FLUSH) || branch_taken;

  // Controls act in the same cycle, so they are decoded directly from state and inputs.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
    end else if (flushing) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fcnt        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (mem_busy) begin
      // EX is frozen, so a pending branch_taken is still there when busy drops.
      if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end else if (state == FLUSH) begin
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      fcnt <= fcnt - FW'(1);
      if (fcnt == FW'(1)) state <= RUN;
    end else if (branch_taken) begin
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      if (FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        fcnt  <= FW'(FLUSH_CYCLES - 1);
      end
    end else if (load_use) begin
      if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl; per-cycle control words are
//            queued with the stimulus and compared mid-cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  // Control word order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold}
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_BUSY = 5'b00001;
  localparam logic [4:0] C_FLSH = 5'b11110;
  localparam logic [4:0] C_STL  = 5'b00010;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic        id_uses_rs1, id_uses_rs2, ID_EX_MemRead, branch_taken, mem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic [31:0] stall_count, flush_count;
  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, id_ex_hold4;
  logic [3:0]  stall_count4, flush_count4;
  logic [4:0]  ctrl;

  int total = 0;
  int bad   = 0;
  logic [4:0] expq[$];

  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold};

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .id_ex_bubble(id_ex_bubble4), .id_ex_hold(id_ex_hold4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  task automatic clr();
    IF_ID_rs1 = 0; IF_ID_rs2 = 0; ID_EX_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ID_EX_MemRead = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic hazard_rs2(input logic [4:0] rd);
    ID_EX_MemRead = 1; ID_EX_rd = rd; IF_ID_rs2 = 5; id_uses_rs2 = 1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    clr();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      expq.push_back(C_RST);
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL reset_ctrl cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 0 || flush_count !== 0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    reset = 0;
    expq.push_back(C_NORM);
    @(negedge clk);
    e = expq.pop_front();
    total++;
    if (ctrl !== e) begin bad++; $display("FAIL reset_release got=%b want=%b", ctrl, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [4:0] e;
    for (int i = 0; i < 6; i++) begin
      clr();
      case (i)
        0: begin hazard_rs2(5); expq.push_back(C_STL); end
        1: begin ID_EX_rd = 5; IF_ID_rs2 = 5; id_uses_rs2 = 1; expq.push_back(C_NORM); end
        2: begin hazard_rs2(0); IF_ID_rs2 = 0; expq.push_back(C_NORM); end
        3: begin ID_EX_MemRead = 1; ID_EX_rd = 7; IF_ID_rs1 = 7; id_uses_rs1 = 1; expq.push_back(C_STL); end
        4: begin ID_EX_MemRead = 1; ID_EX_rd = 7; IF_ID_rs2 = 7; id_uses_rs2 = 0; expq.push_back(C_NORM); end
        default: begin ID_EX_MemRead = 1; ID_EX_rd = 9; IF_ID_rs1 = 8; IF_ID_rs2 = 10;
                       id_uses_rs1 = 1; id_uses_rs2 = 1; expq.push_back(C_NORM); end
      endcase
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL load_use cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
      if (i == 1) begin
        total++;
        if (stall_count !== 1) begin bad++; $display("FAIL load_use_cnt got=%0d want=1", stall_count); end
      end
    end
    total++;
    if (stall_count !== 2) begin bad++; $display("FAIL load_use_cnt2 got=%0d want=2", stall_count); end
  endtask

  task automatic test_branch();
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      clr();
      branch_taken = (i == 0);
      expq.push_back(i < 2 ? C_FLSH : C_NORM);
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL branch cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
    end
    total++;
    if (flush_count !== 2) begin bad++; $display("FAIL branch_cnt got=%0d want=2", flush_count); end
  endtask

  task automatic test_branch_vs_load_use();
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      clr();
      if (i < 2) hazard_rs2(5);
      branch_taken = (i == 0);
      expq.push_back(i < 2 ? C_FLSH : C_NORM);
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL br_lu cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 2 || flush_count !== 4) begin
      bad++; $display("FAIL br_lu_cnt got=%0d/%0d want=2/4", stall_count, flush_count);
    end
  endtask

  task automatic test_busy_in_flush();
    logic [4:0] e;
    for (int i = 0; i < 7; i++) begin
      clr();
      branch_taken = (i == 0);
      mem_busy = (i >= 1 && i <= 4);
      if (i == 0 || i == 5) expq.push_back(C_FLSH);
      else if (i == 6) expq.push_back(C_NORM);
      else expq.push_back(C_BUSY);
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL busy_flush cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 6 || flush_count !== 6) begin
      bad++; $display("FAIL busy_flush_cnt got=%0d/%0d want=6/6", stall_count, flush_count);
    end
  endtask

  task automatic test_busy_branch();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      clr();
      branch_taken = (i <= 1);
      mem_busy = (i == 0);
      if (hazard_on(i)) hazard_rs2(5);
      expq.push_back(i == 0 ? C_BUSY : (i == 3 ? C_NORM : C_FLSH));
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL busy_branch cyc%0d got=%b want=%b", i, ctrl, e); end
      @(posedge clk); #1;
    end
    total++;
    if (stall_count !== 7 || flush_count !== 8) begin
      bad++; $display("FAIL busy_branch_cnt got=%0d/%0d want=7/8", stall_count, flush_count);
    end
  endtask

  function automatic bit hazard_on(input int i);
    return (i == 0);
  endfunction

  task automatic test_reset_mid_flush();
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      clr();
      branch_taken = (i == 0);
      reset = (i == 1);
      expq.push_back(i == 0 ? C_FLSH : (i == 1 ? C_RST : C_NORM));
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e) begin bad++; $display("FAIL rst_flush cyc%0d got=%b want=%b", i, ctrl, e); end
      if (i == 1) begin
        total++;
        if (stall_count !== 0 || flush_count !== 0) begin
          bad++; $display("FAIL rst_flush_cnt got=%0d/%0d want=0/0", stall_count, flush_count);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    logic [4:0] e;
    for (int i = 0; i < 20; i++) begin
      clr();
      mem_busy = 1;
      expq.push_back(C_BUSY);
      @(negedge clk);
      e = expq.pop_front();
      total++;
      if (ctrl !== e || id_ex_hold4 !== 1'b1) begin
        bad++; $display("FAIL sat_ctrl cyc%0d got=%b want=%b", i, ctrl, e);
      end
      @(posedge clk); #1;
    end
    clr();
    total++;
    if (stall_count4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d want=15", stall_count4); end
    total++;
    if (stall_count !== 20) begin bad++; $display("FAIL sat_cnt32 got=%0d want=20", stall_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_vs_load_use();
    test_busy_in_flush();
    test_busy_branch();
    test_reset_mid_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
